// File: rtl/product_accumulator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : product_accumulator_pkg
//  Description : Shared constants for the product accumulator: FSM state
//                encoding, default datapath widths and block counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package product_accumulator_pkg;

    // Default widths: the 3x3 multiplier emits 6-bit products.
    localparam int c_prod_w_dflt = 6;
    localparam int c_acc_w_dflt  = 12;

    // Block counter width; BLOCK_LEN is limited to 1..255.
    localparam int c_cnt_w = 8;

    // FSM state encoding.
    localparam logic [0:0] c_st_accum = 1'b0;
    localparam logic [0:0] c_st_hold  = 1'b1;

endpackage : product_accumulator_pkg
`default_nettype wire

// File: rtl/product_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : product_accumulator_if
//  Description : Product input stream plus block result stream of the
//                product accumulator. The master side is the producer of
//                products and consumer of results; the slave side is the
//                accumulator itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface product_accumulator_if
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W = c_prod_w_dflt,
    parameter int ACC_W  = c_acc_w_dflt
);

    logic                 in_valid;
    logic                 in_ready;
    logic [PROD_W-1:0]    in_product;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_W-1:0]     out_sum;
    logic                 out_overflow;
    logic [c_cnt_w-1:0]   out_count;

    modport master (
        output in_valid,
        input  in_ready,
        output in_product,
        output in_last,
        input  out_valid,
        output out_ready,
        input  out_sum,
        input  out_overflow,
        input  out_count
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_product,
        input  in_last,
        output out_valid,
        input  out_ready,
        output out_sum,
        output out_overflow,
        output out_count
    );

endinterface : product_accumulator_if
`default_nettype wire

// File: rtl/product_accumulator_acc_adder.sv
`default_nettype none
// ============================================================================
//  Module      : product_accumulator_acc_adder
//  Description : Combinational ACC_W-bit unsigned adder with carry-out.
//  Revision    : 1.0 - initial release
// ============================================================================
module product_accumulator_acc_adder
    import product_accumulator_pkg::*;
#(
    parameter int ACC_W = c_acc_w_dflt
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_carry
);

    // One extra bit so the carry out of ACC_W is captured.
    logic [ACC_W:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b};
    assign o_sum   = w_full[ACC_W-1:0];
    assign o_carry = w_full[ACC_W];

endmodule : product_accumulator_acc_adder
`default_nettype wire

// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : product_accumulator
//  Description : Sums blocks of unsigned products into an ACC_W accumulator.
//                A block closes after BLOCK_LEN products or on an in_last
//                beat; its total is then held until the consumer takes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W    = c_prod_w_dflt,
    parameter int ACC_W     = c_acc_w_dflt,
    parameter int BLOCK_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    product_accumulator_if.slave bus
);

    localparam logic [c_cnt_w-1:0] c_block_len = c_cnt_w'(BLOCK_LEN);

    logic [0:0]         r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_ovf;
    logic [ACC_W-1:0]   r_out_sum;
    logic               r_out_ovf;
    logic [c_cnt_w-1:0] r_out_cnt;

    logic [PROD_W-1:0]  w_prod;
    logic [ACC_W-1:0]   w_prod_ext;
    logic [ACC_W-1:0]   w_sum;
    logic               w_carry;
    logic [c_cnt_w-1:0] w_cnt_inc;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_final;

    assign w_prod     = bus.in_product;
    assign w_prod_ext = ACC_W'(w_prod);

    // Ready depends on state alone so upstream sees no path from valid/ready.
    assign w_in_ready = (r_state == c_st_accum);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_final    = bus.in_last || (w_cnt_inc == c_block_len);

    product_accumulator_acc_adder #(
        .ACC_W (ACC_W)
    ) u_adder (
        .i_a     (r_acc),
        .i_b     (w_prod_ext),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // Block FSM: accumulate accepted beats, latch the total on the final beat,
    // then hold it until the consumer accepts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_accum;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_out_sum <= '0;
            r_out_ovf <= 1'b0;
            r_out_cnt <= '0;
        end else begin
            case (r_state)
                c_st_accum: begin
                    if (w_accept) begin
                        if (w_final) begin
                            r_out_sum <= w_sum;
                            r_out_ovf <= r_ovf | w_carry;
                            r_out_cnt <= w_cnt_inc;
                            r_acc     <= '0;
                            r_cnt     <= '0;
                            r_ovf     <= 1'b0;
                            r_state   <= c_st_hold;
                        end else begin
                            r_acc <= w_sum;
                            r_cnt <= w_cnt_inc;
                            r_ovf <= r_ovf | w_carry;
                        end
                    end
                end
                c_st_hold: begin
                    if (bus.out_ready) begin
                        r_state <= c_st_accum;
                    end
                end
                default: r_state <= c_st_accum;
            endcase
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = (r_state == c_st_hold);
    assign bus.out_sum      = r_out_sum;
    assign bus.out_overflow = r_out_ovf;
    assign bus.out_count    = r_out_cnt;

endmodule : product_accumulator
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_product_accumulator
//  Description : Self-checking bench for product_accumulator. Two instances
//                (ACC_W=12 and ACC_W=8, BLOCK_LEN=8) see identical stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_product_accumulator;
    import product_accumulator_pkg::*;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       in_valid   = 1'b0;
    logic       in_last    = 1'b0;
    logic       out_ready  = 1'b1;
    logic [5:0] in_product = '0;

    int n_checks  = 0;
    int n_fails   = 0;
    int n_accepts = 0;

    always #5 clk = ~clk;

    product_accumulator_if #(.PROD_W(6), .ACC_W(12)) bus12 ();
    product_accumulator_if #(.PROD_W(6), .ACC_W(8))  bus8  ();

    assign bus12.in_valid   = in_valid;
    assign bus12.in_product = in_product;
    assign bus12.in_last    = in_last;
    assign bus12.out_ready  = out_ready;
    assign bus8.in_valid    = in_valid;
    assign bus8.in_product  = in_product;
    assign bus8.in_last     = in_last;
    assign bus8.out_ready   = out_ready;

    product_accumulator #(.PROD_W(6), .ACC_W(12), .BLOCK_LEN(8)) u_dut12 (
        .clk (clk),
        .rst (rst),
        .bus (bus12)
    );

    product_accumulator #(.PROD_W(6), .ACC_W(8), .BLOCK_LEN(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Result of one block as both widths should report it.
    typedef struct {
        int sum12;
        int sum8;
        int cnt;
        int ovf12;
        int ovf8;
    } res_t;

    res_t exp_q[$];
    res_t r_exp;
    int   m_total = 0;
    int   m_cnt   = 0;

    // Reference model: exact integer total of accepted products per block.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_total = 0;
                m_cnt   = 0;
                exp_q.delete();
            end else begin
                if (bus12.out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_result", 1, 0);
                    end else begin
                        r_exp = exp_q.pop_front();
                        check("sb_sum12",   int'(bus12.out_sum),      r_exp.sum12);
                        check("sb_count12", int'(bus12.out_count),    r_exp.cnt);
                        check("sb_ovf12",   int'(bus12.out_overflow), r_exp.ovf12);
                        check("sb_valid8",  int'(bus8.out_valid),     1);
                        check("sb_sum8",    int'(bus8.out_sum),       r_exp.sum8);
                        check("sb_count8",  int'(bus8.out_count),     r_exp.cnt);
                        check("sb_ovf8",    int'(bus8.out_overflow),  r_exp.ovf8);
                    end
                end
                if (in_valid && bus12.in_ready) begin
                    n_accepts++;
                    m_total += int'(in_product);
                    m_cnt++;
                    if (in_last || m_cnt == 8) begin
                        exp_q.push_back('{m_total % 4096, m_total % 256, m_cnt,
                                          int'(m_total >= 4096), int'(m_total >= 256)});
                        m_total = 0;
                        m_cnt   = 0;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Present one beat and wait until it is taken; returns 1 time unit after
    // the accepting edge.
    task automatic send_beat(input logic [5:0] p, input logic l);
        int guard;
        guard      = 0;
        in_valid   = 1'b1;
        in_product = p;
        in_last    = l;
        while (!bus12.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_out(input string tag, input int s12, input int s8, input int cnt,
                             input int o12, input int o8);
        check({tag, "_valid"},   int'(bus12.out_valid),    1);
        check({tag, "_inready"}, int'(bus12.in_ready),     0);
        check({tag, "_sum12"},   int'(bus12.out_sum),      s12);
        check({tag, "_count"},   int'(bus12.out_count),    cnt);
        check({tag, "_ovf12"},   int'(bus12.out_overflow), o12);
        check({tag, "_sum8"},    int'(bus8.out_sum),       s8);
        check({tag, "_ovf8"},    int'(bus8.out_overflow),  o8);
    endtask

    typedef struct {
        logic [7:0][5:0] prods;
        int              n;
        logic            last;
        int              s12;
        int              s8;
        int              cnt;
        int              o12;
        int              o8;
    } vec_t;

    localparam int c_nv = 8;
    vec_t vecs[c_nv];
    int   acc_snap;

    initial begin
        // prods[0] is the first beat.
        vecs[0] = '{{8{6'd49}}, 8, 1'b0, 392, 136, 8, 0, 1};
        vecs[1] = '{{{7{6'd0}}, 6'd5}, 1, 1'b1, 5, 5, 1, 0, 0};
        vecs[2] = '{{8{6'd0}}, 8, 1'b0, 0, 0, 8, 0, 0};
        vecs[3] = '{{8{6'd63}}, 8, 1'b0, 504, 248, 8, 0, 1};
        vecs[4] = '{{{4{6'd0}}, {4{6'd63}}}, 4, 1'b1, 252, 252, 4, 0, 0};
        vecs[5] = '{{{3{6'd0}}, {5{6'd60}}}, 5, 1'b1, 300, 44, 5, 0, 1};
        vecs[6] = '{{6'd0, 6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1}, 7, 1'b1, 28, 28, 7, 0, 0};
        vecs[7] = '{{6'd8, 6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1}, 8, 1'b0, 36, 36, 8, 0, 0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_valid12", int'(bus12.out_valid),    0);
        check("rst_ready12", int'(bus12.in_ready),     1);
        check("rst_sum12",   int'(bus12.out_sum),      0);
        check("rst_count12", int'(bus12.out_count),    0);
        check("rst_ovf12",   int'(bus12.out_overflow), 0);
        check("rst_valid8",  int'(bus8.out_valid),     0);
        check("rst_sum8",    int'(bus8.out_sum),       0);

        // Table of back-to-back blocks, result taken immediately.
        for (int v = 0; v < c_nv; v++) begin
            for (int b = 0; b < vecs[v].n; b++) begin
                send_beat(vecs[v].prods[b], vecs[v].last && (b == vecs[v].n - 1));
            end
            check_out($sformatf("vec%0d", v), vecs[v].s12, vecs[v].s8, vecs[v].cnt,
                      vecs[v].o12, vecs[v].o8);
            @(posedge clk); #1;
            check($sformatf("vec%0d_ready_back", v), int'(bus12.in_ready),  1);
            check($sformatf("vec%0d_valid_drop", v), int'(bus12.out_valid), 0);
        end

        // Gaps of two idle cycles between beats.
        send_beat(6'd1, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
            check("gap_valid", int'(bus12.out_valid), 0);
            check("gap_ready", int'(bus12.in_ready),  1);
        end
        send_beat(6'd2, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        send_beat(6'd3, 1'b1);
        check_out("gap", 6, 6, 3, 0, 0);
        @(posedge clk); #1;

        // Backpressure: result held while upstream keeps offering 7.
        out_ready = 1'b0;
        send_beat(6'd4, 1'b0);
        send_beat(6'd5, 1'b0);
        send_beat(6'd6, 1'b1);
        in_valid   = 1'b1;
        in_product = 6'd7;
        acc_snap   = n_accepts;
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", int'(bus12.out_valid), 1);
            check("bp_ready", int'(bus12.in_ready),  0);
            check("bp_sum",   int'(bus12.out_sum),   15);
            check("bp_count", int'(bus12.out_count), 3);
            @(posedge clk); #1;
        end
        check("bp_no_accept", n_accepts, acc_snap);
        out_ready = 1'b1;
        send_beat(6'd7, 1'b0);
        for (int k = 0; k < 7; k++) send_beat(6'd1, 1'b0);
        check_out("bp_next", 14, 14, 8, 0, 0);
        @(posedge clk); #1;

        // Reset in the middle of a block discards the partial sum.
        for (int k = 0; k < 4; k++) send_beat(6'd10, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_valid", int'(bus12.out_valid),    0);
        check("mid_rst_ready", int'(bus12.in_ready),     1);
        check("mid_rst_sum",   int'(bus12.out_sum),      0);
        check("mid_rst_count", int'(bus12.out_count),    0);
        check("mid_rst_ovf8",  int'(bus8.out_overflow),  0);
        for (int k = 0; k < 8; k++) send_beat(6'd1, 1'b0);
        check_out("post_rst", 8, 8, 8, 0, 0);
        @(posedge clk); #1;

        // Random traffic checked by the reference model.
        for (int c = 0; c < 600; c++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            in_product = 6'($urandom_range(0, 49));
            in_last    = ($urandom_range(0, 9) < 2);
            out_ready  = ($urandom_range(0, 9) < 6);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_product_accumulator
`default_nettype wire
